// File: rtl/uart_dbg_loader.sv
// UART byte-stream command parser: halt/run CPU, single-word debug writes and reads.
// Define DBG_LOADER_BURST_EN to add the 'B' burst-write command.
module uart_dbg_loader #(
  parameter int unsigned TIMEOUT_CYC   = 100000,
  parameter int unsigned RD_LAT        = 1,
  parameter bit          HALT_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        dbg_mem_op,
  output logic [31:0] dbg_adr,
  output logic [31:0] dbg_do,
  output logic [3:0]  dbg_wren,
  input  logic [31:0] dbg_di,
  output logic        cpu_n_reset
);

  localparam logic [7:0] CMD_HALT  = 8'h48;
  localparam logic [7:0] CMD_GO    = 8'h47;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
`ifdef DBG_LOADER_BURST_EN
  localparam logic [7:0] CMD_BURST = 8'h42;
`endif
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;
  localparam logic [7:0] RSP_UNK   = 8'h3F;

  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_ACCESS, S_WAIT_RD, S_TX
`ifdef DBG_LOADER_BURST_EN
    , S_CNT
`endif
  } state_t;

  state_t            r_state;
  logic              r_is_wr;
`ifdef DBG_LOADER_BURST_EN
  logic              r_burst;
`endif
  logic [1:0]        r_byte_cnt;
  logic [31:0]       r_addr;
  logic [31:0]       r_data;
  logic [7:0]        r_words;
  logic [TO_W-1:0]   r_to_cnt;
  logic [LAT_W-1:0]  r_lat_cnt;
  logic [1:0]        r_tx_left;
  logic [23:0]       r_tx_shift;
  logic              r_tx_valid;
  logic [7:0]        r_tx_data;
  logic              r_mem_op;
  logic [31:0]       r_adr;
  logic [31:0]       r_do;
  logic [3:0]        r_wren;
  logic              r_cpu_n_reset;

  logic              w_halted;
  logic              w_to_expired;
  logic [31:0]       w_addr_next;
  logic [31:0]       w_data_next;

  // Fields arrive little-endian: each new byte enters at the top and slides down.
  assign w_addr_next  = {rx_data, r_addr[31:8]};
  assign w_data_next  = {rx_data, r_data[31:8]};
  assign w_halted     = ~r_cpu_n_reset;
  assign w_to_expired = (r_to_cnt == TO_LAST);

  // NOTE: every register below is updated with <= so all reads in this block
  // see the pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_is_wr       <= 1'b0;
`ifdef DBG_LOADER_BURST_EN
      r_burst       <= 1'b0;
`endif
      r_byte_cnt    <= '0;
      r_addr        <= '0;
      r_data        <= '0;
      r_words       <= '0;
      r_to_cnt      <= '0;
      r_lat_cnt     <= '0;
      r_tx_left     <= '0;
      r_tx_shift    <= '0;
      r_tx_valid    <= 1'b0;
      r_tx_data     <= '0;
      r_mem_op      <= 1'b0;
      r_adr         <= '0;
      r_do          <= '0;
      r_wren        <= '0;
      r_cpu_n_reset <= ~HALT_ON_RESET;
    end else begin
      // NOTE: the access strobe defaults low each cycle so a pulse lasts exactly one cycle.
      r_mem_op <= 1'b0;
      r_wren   <= 4'h0;

      case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            r_byte_cnt <= '0;
            r_to_cnt   <= '0;
`ifdef DBG_LOADER_BURST_EN
            r_burst    <= 1'b0;
`endif
            case (rx_data)
              CMD_WRITE: begin
                r_is_wr <= 1'b1;
                r_state <= S_ADDR;
              end
              CMD_READ: begin
                r_is_wr <= 1'b0;
                r_state <= S_ADDR;
              end
`ifdef DBG_LOADER_BURST_EN
              CMD_BURST: begin
                r_is_wr <= 1'b1;
                r_burst <= 1'b1;
                r_state <= S_ADDR;
              end
`endif
              default: begin
                r_tx_valid <= 1'b1;
                r_tx_left  <= 2'd0;
                r_state    <= S_TX;
                r_tx_data  <= (rx_data == CMD_HALT || rx_data == CMD_GO) ? RSP_OK : RSP_UNK;
                if (rx_data == CMD_HALT)    r_cpu_n_reset <= 1'b0;
                else if (rx_data == CMD_GO) r_cpu_n_reset <= 1'b1;
              end
            endcase
          end
        end

        S_ADDR: begin
          if (rx_valid) begin
            r_to_cnt   <= '0;
            r_addr     <= w_addr_next;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
`ifdef DBG_LOADER_BURST_EN
              if (r_burst) r_state <= S_CNT;
              else
`endif
              if (r_is_wr) begin
                r_words <= 8'd1;
                r_state <= S_DATA;
              end else if (w_halted) begin
                r_mem_op <= 1'b1;
                r_adr    <= w_addr_next;
                r_state  <= S_ACCESS;
              end else begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= RSP_ERR;
                r_tx_left  <= 2'd0;
                r_state    <= S_TX;
              end
            end
          end else if (w_to_expired) begin
            r_state <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

`ifdef DBG_LOADER_BURST_EN
        S_CNT: begin
          if (rx_valid) begin
            r_to_cnt <= '0;
            r_words  <= rx_data;
            if (rx_data == 8'd0) begin
              r_tx_valid <= 1'b1;
              r_tx_data  <= w_halted ? RSP_OK : RSP_ERR;
              r_tx_left  <= 2'd0;
              r_state    <= S_TX;
            end else begin
              r_state <= S_DATA;
            end
          end else if (w_to_expired) begin
            r_state <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
`endif

        S_DATA: begin
          if (rx_valid) begin
            r_to_cnt   <= '0;
            r_data     <= w_data_next;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              // Burst words before the last are written while staying here, so streaming bytes are never dropped.
              if (w_halted) begin
                r_mem_op <= 1'b1;
                r_wren   <= 4'hF;
                r_adr    <= r_addr;
                r_do     <= w_data_next;
                r_addr   <= r_addr + 32'd4;
              end
              if (r_words == 8'd1) begin
                if (w_halted) begin
                  r_state <= S_ACCESS;
                end else begin
                  r_tx_valid <= 1'b1;
                  r_tx_data  <= RSP_ERR;
                  r_tx_left  <= 2'd0;
                  r_state    <= S_TX;
                end
              end else begin
                r_words <= r_words - 8'd1;
              end
            end
          end else if (w_to_expired) begin
            r_state <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        S_ACCESS: begin
          if (r_is_wr) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= RSP_OK;
            r_tx_left  <= 2'd0;
            r_state    <= S_TX;
          end else begin
            r_lat_cnt <= '0;
            r_state   <= S_WAIT_RD;
          end
        end

        S_WAIT_RD: begin
          if (r_lat_cnt == LAT_LAST) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= dbg_di[7:0];
            r_tx_shift <= dbg_di[31:8];
            r_tx_left  <= 2'd3;
            r_state    <= S_TX;
          end else begin
            r_lat_cnt <= r_lat_cnt + 1'b1;
          end
        end

        S_TX: begin
          if (tx_ready) begin
            if (r_tx_left == 2'd0) begin
              r_tx_valid <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_tx_data  <= r_tx_shift[7:0];
              r_tx_shift <= {8'h00, r_tx_shift[23:8]};
              r_tx_left  <= r_tx_left - 2'd1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign tx_valid    = r_tx_valid;
  assign tx_data     = r_tx_data;
  assign dbg_mem_op  = r_mem_op;
  assign dbg_adr     = r_adr;
  assign dbg_do      = r_do;
  assign dbg_wren    = r_wren;
  assign cpu_n_reset = r_cpu_n_reset;

endmodule

// File: tb/tb_uart_dbg_loader.sv
// Self-checking bench for uart_dbg_loader: directed scenarios plus randomized command frames
// checked against a host-level model (expected replies, expected accesses, expected memory).
module tb_uart_dbg_loader;

  localparam int unsigned TIMEOUT_T = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_ready = 1'b0;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        dbg_mem_op;
  logic [31:0] dbg_adr;
  logic [31:0] dbg_do;
  logic [3:0]  dbg_wren;
  logic [31:0] dbg_di;
  logic        cpu_n_reset;

  uart_dbg_loader #(
    .TIMEOUT_CYC   (TIMEOUT_T),
    .RD_LAT        (1),
    .HALT_ON_RESET (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .tx_ready    (tx_ready),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .dbg_mem_op  (dbg_mem_op),
    .dbg_adr     (dbg_adr),
    .dbg_do      (dbg_do),
    .dbg_wren    (dbg_wren),
    .dbg_di      (dbg_di),
    .cpu_n_reset (cpu_n_reset)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  wren;
  } acc_t;

  int n_checks = 0;
  int n_fail   = 0;
  int ready_mode = 1;  // 0 = hold low, 1 = hold high, 2 = random

  logic [7:0]  rx_q[$];       // bytes the host received
  acc_t        acc_q[$];      // access cycles seen on the debug port
  logic [7:0]  fr_q[$];       // frame to send
  logic [7:0]  exp_rep_q[$];  // expected reply
  acc_t        exp_acc_q[$];  // expected accesses
  bit [31:0]   ref_mem [bit [31:0]];
  bit [31:0]   sim_mem [bit [31:0]];
  bit          ref_halted;

  function automatic logic [31:0] def_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_96E1;
  endfunction

  // Debug memory: read data is valid only in the cycle RD_LAT=1 after the access cycle.
  logic        di_vld = 1'b0;
  logic [31:0] di_word = 32'h0;
  always @(posedge clk) begin
    di_vld <= (dbg_mem_op === 1'b1) && (dbg_wren === 4'h0);
    if (dbg_mem_op === 1'b1 && dbg_wren === 4'h0)
      di_word <= sim_mem.exists(dbg_adr) ? sim_mem[dbg_adr] : def_word(dbg_adr);
  end
  assign dbg_di = di_vld ? di_word : 32'hBAD0_BAD0;

  acc_t mon_e;
  always @(negedge clk) begin
    if (dbg_mem_op === 1'b1) begin
      mon_e.adr  = dbg_adr;
      mon_e.dat  = dbg_do;
      mon_e.wren = dbg_wren;
      acc_q.push_back(mon_e);
      if (dbg_wren === 4'hF) sim_mem[dbg_adr] = dbg_do;
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) rx_q.push_back(tx_data);
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       tx_ready = 1'b0;
      1:       tx_ready = 1'b1;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic clr_exp();
    fr_q.delete();
    exp_rep_q.delete();
    exp_acc_q.delete();
  endtask

  task automatic push_fr_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) fr_q.push_back(w[8*k +: 8]);
  endtask

  task automatic push_rep_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) exp_rep_q.push_back(w[8*k +: 8]);
  endtask

  task automatic exp_write(input logic [31:0] a, input logic [31:0] d);
    acc_t e;
    e.adr = a; e.dat = d; e.wren = 4'hF;
    exp_acc_q.push_back(e);
    ref_mem[a] = d;
  endtask

  task automatic build_simple(input logic [7:0] b);
    clr_exp();
    fr_q.push_back(b);
    if (b == 8'h48) begin ref_halted = 1'b1; exp_rep_q.push_back(8'h4B); end
    else if (b == 8'h47) begin ref_halted = 1'b0; exp_rep_q.push_back(8'h4B); end
    else exp_rep_q.push_back(8'h3F);
  endtask

  task automatic build_write(input logic [31:0] a, input logic [31:0] d);
    clr_exp();
    fr_q.push_back(8'h57);
    push_fr_word(a);
    push_fr_word(d);
    if (ref_halted) begin
      exp_write(a, d);
      exp_rep_q.push_back(8'h4B);
    end else exp_rep_q.push_back(8'h45);
  endtask

  task automatic build_read(input logic [31:0] a);
    acc_t e;
    clr_exp();
    fr_q.push_back(8'h52);
    push_fr_word(a);
    if (ref_halted) begin
      e.adr = a; e.dat = 32'h0; e.wren = 4'h0;
      exp_acc_q.push_back(e);
      push_rep_word(ref_mem.exists(a) ? ref_mem[a] : def_word(a));
    end else exp_rep_q.push_back(8'h45);
  endtask

  task automatic build_burst(input logic [31:0] a, input logic [7:0] n);
    logic [31:0] w;
    clr_exp();
    fr_q.push_back(8'h42);
    push_fr_word(a);
    fr_q.push_back(n);
    for (int k = 0; k < int'(n); k++) begin
      w = $urandom;
      push_fr_word(w);
      if (ref_halted) exp_write(a + 32'(4 * k), w);
    end
    exp_rep_q.push_back(ref_halted ? 8'h4B : 8'h45);
  endtask

  function automatic bit is_cmd(input logic [7:0] b);
`ifdef DBG_LOADER_BURST_EN
    if (b == 8'h42) return 1'b1;
`endif
    return (b == 8'h48) || (b == 8'h47) || (b == 8'h57) || (b == 8'h52);
  endfunction

  // Sends fr_q (optionally pausing gap_len cycles after byte gap_after), collects the reply,
  // and compares replies and debug-port accesses with the expectations.
  task automatic run_frame(input string tag, input int gap_after, input int gap_len);
    int n;
    rx_q.delete();
    acc_q.delete();
    foreach (fr_q[i]) begin
      send_byte(fr_q[i]);
      if (i == gap_after) repeat (gap_len) tick();
    end
    for (int i = 0; i < 300 && rx_q.size() < exp_rep_q.size(); i++) tick();
    repeat (6) tick();
    check({tag, ".nrep"}, 64'(rx_q.size()), 64'(exp_rep_q.size()));
    n = (rx_q.size() < exp_rep_q.size()) ? rx_q.size() : exp_rep_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s.rep%0d", tag, i), rx_q[i], exp_rep_q[i]);
    check({tag, ".nacc"}, 64'(acc_q.size()), 64'(exp_acc_q.size()));
    n = (acc_q.size() < exp_acc_q.size()) ? acc_q.size() : exp_acc_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.adr%0d", tag, i), acc_q[i].adr, exp_acc_q[i].adr);
      check($sformatf("%s.wren%0d", tag, i), acc_q[i].wren, exp_acc_q[i].wren);
      if (exp_acc_q[i].wren == 4'hF)
        check($sformatf("%s.do%0d", tag, i), acc_q[i].dat, exp_acc_q[i].dat);
    end
    check({tag, ".idle"}, tx_valid, 1'b0);
  endtask

  initial begin
    logic [7:0]  d0;
    logic [31:0] a;
    logic [7:0]  b;
    int          op;

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    ref_halted = 1'b1;
    check("rst.cpu_n_reset", cpu_n_reset, 1'b0);
    check("rst.tx_valid", tx_valid, 1'b0);
    check("rst.tx_data", tx_data, 8'h00);
    check("rst.mem_op", dbg_mem_op, 1'b0);
    check("rst.wren", dbg_wren, 4'h0);
    check("rst.adr", dbg_adr, 32'h0);
    check("rst.do", dbg_do, 32'h0);

    // Run / halt
    build_simple(8'h47); run_frame("go", -1, 0);
    check("go.cpu", cpu_n_reset, 1'b1);
    build_simple(8'h48); run_frame("halt", -1, 0);
    check("halt.cpu", cpu_n_reset, 1'b0);

    // Directed write: 57 50 00 02 00 6F F0 9F C1
    build_write(32'h0002_0050, 32'hC19F_F06F);
    run_frame("wr", -1, 0);

    // Directed read with the memory now holding 0xE0DFF06F -> 6F F0 DF E0
    ref_mem[32'h0002_0050] = 32'hE0DF_F06F;
    sim_mem[32'h0002_0050] = 32'hE0DF_F06F;
    build_read(32'h0002_0050);
    run_frame("rd", -1, 0);
    check("rd.b0", exp_rep_q[0], 8'h6F);

    // CPU running: accesses refused, unknown byte still answered
    build_simple(8'h47); run_frame("go2", -1, 0);
    build_write(32'h0002_0100, 32'h1234_5678); run_frame("run.wr", -1, 0);
    build_read(32'h0002_0050); run_frame("run.rd", -1, 0);
    build_simple(8'h00); run_frame("unk", -1, 0);
    build_simple(8'h48); run_frame("halt2", -1, 0);

    // Gap just below the timeout keeps the frame alive
    build_write(32'h0002_0200, 32'hCAFE_F00D);
    run_frame("gap", 2, TIMEOUT_T - 5);

    // Gap beyond the timeout aborts the frame silently
    rx_q.delete(); acc_q.delete();
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h03); send_byte(8'h02);
    repeat (TIMEOUT_T + 10) tick();
    check("to.nrep", 64'(rx_q.size()), 64'd0);
    check("to.nacc", 64'(acc_q.size()), 64'd0);
    build_simple(8'h48); run_frame("to.halt", -1, 0);

    // Reply stalled by tx_ready=0; rx traffic meanwhile is ignored
    ready_mode = 0;
    tick();
    build_read(32'h0002_0050);
    rx_q.delete(); acc_q.delete();
    foreach (fr_q[i]) send_byte(fr_q[i]);
    for (int i = 0; i < 20 && tx_valid !== 1'b1; i++) tick();
    check("stall.offer", tx_valid, 1'b1);
    d0 = tx_data;
    check("stall.byte0", d0, exp_rep_q[0]);
    for (int i = 0; i < 50; i++) begin
      rx_valid = (i == 5) || (i == 15) || (i == 25);
      rx_data  = (i == 5) ? 8'h47 : (i == 15) ? 8'h57 : 8'hA5;
      tick();
      check($sformatf("stall.valid%0d", i), tx_valid, 1'b1);
      check($sformatf("stall.data%0d", i), tx_data, d0);
    end
    rx_valid = 1'b0;
    ready_mode = 1;
    for (int i = 0; i < 50 && rx_q.size() < 4; i++) tick();
    repeat (4) tick();
    check("stall.nrep", 64'(rx_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < rx_q.size(); i++)
      check($sformatf("stall.rep%0d", i), rx_q[i], exp_rep_q[i]);
    check("stall.nacc", 64'(acc_q.size()), 64'd1);
    check("stall.cpu", cpu_n_reset, 1'b0);
    build_simple(8'h48); run_frame("stall.after", -1, 0);

    // Reset with a pending reply byte, then with a partial frame
    ready_mode = 0;
    tick();
    rx_q.delete();
    send_byte(8'h47);
    check("rstp.pending", tx_valid, 1'b1);
    reset = 1'b1; tick(); reset = 1'b0;
    ref_halted = 1'b1;
    check("rstp.tx_valid", tx_valid, 1'b0);
    check("rstp.cpu", cpu_n_reset, 1'b0);
    ready_mode = 1;
    repeat (5) tick();
    check("rstp.nrep", 64'(rx_q.size()), 64'd0);
    send_byte(8'h57); send_byte(8'h10); send_byte(8'h20);
    reset = 1'b1; tick(); reset = 1'b0;
    build_read(32'h0002_0050); run_frame("rstf.rd", -1, 0);

`ifdef DBG_LOADER_BURST_EN
    build_burst(32'h0002_0000, 8'd2); run_frame("burst", -1, 0);
    build_burst(32'h0002_0040, 8'd0); run_frame("burst0", -1, 0);
    build_burst(32'h0002_0080, 8'd5); run_frame("burst5", -1, 0);
    build_simple(8'h47); run_frame("burst.go", -1, 0);
    build_burst(32'h0002_0000, 8'd2); run_frame("burst.run", -1, 0);
    build_simple(8'h48); run_frame("burst.halt", -1, 0);
`else
    build_simple(8'h42); run_frame("b_unk", -1, 0);
`endif

    // Randomized frames with random transmitter back-pressure
    ready_mode = 2;
    for (int it = 0; it < 40; it++) begin
      op = int'($urandom_range(0, 6));
      a = ($urandom_range(0, 1) == 1) ? $urandom : (32'h0002_0000 + 32'($urandom_range(0, 15)) * 4);
      case (op)
        0: build_simple(8'h48);
        1: build_simple(($urandom_range(0, 3) == 0) ? 8'h47 : 8'h48);
        2, 3: build_write(a, $urandom);
        4, 5: build_read(a);
        default: begin
          b = 8'($urandom_range(0, 255));
          while (is_cmd(b)) b = 8'($urandom_range(0, 255));
          build_simple(b);
        end
      endcase
      run_frame($sformatf("rnd%0d", it), -1, 0);
      check($sformatf("rnd%0d.cpu", it), cpu_n_reset, !ref_halted);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
